// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack handshake and buffers
// returned words in a small FIFO feeding IF/ID. Define FETCH_PERF_EN to add perf counters.
module if_fetch_unit #(
    parameter int          PC_W      = 12,
    parameter int          INST_W    = 19,
    parameter int unsigned RESET_PC  = 32'd0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] data,
    output logic [PC_W-1:0]   PCplus,
    output logic              IF_Flush
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_drop_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   req_addr_q, req_addr_d;
    logic              outst_q, outst_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem_q [BUF_DEPTH];
    logic [PC_W-1:0]   pcp_mem_q  [BUF_DEPTH];
    logic              push_s, pop_s, flush_s, ack_s, empty_s;
    logic [PC_W-1:0]   pc_inc_s;

    // Request is gated by reset so it is low as soon as reset asserts, with no clock.
    assign imem_req  = reset & (outst_q | (state_q == ST_DISCARD) | (count_q < DEPTH_C));
    assign imem_addr = outst_q ? req_addr_q : fetch_pc_q;
    assign ack_s     = imem_req & imem_ack;
    assign IF_Flush  = redirect;
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign pc_inc_s  = fetch_pc_q + PC_W'(1'b1);
    assign data      = empty_s ? {INST_W{1'b0}} : inst_mem_q[rd_ptr_q];
    assign PCplus    = empty_s ? {PC_W{1'b0}}   : pcp_mem_q[rd_ptr_q];

    // Next-state: handshake tracking, FETCH/DISCARD sequencing and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        flush_s    = 1'b0;

        if (imem_req) begin
            outst_d    = ~imem_ack;
            req_addr_d = imem_addr;
        end else begin
            outst_d    = 1'b0;
            req_addr_d = req_addr_q;
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_d = redirect_pc;
                    if (imem_req && !imem_ack) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    push_s     = ack_s;
                    pop_s      = ~stall & ~empty_s;
                    fetch_pc_d = ack_s ? pc_inc_s : fetch_pc_q;
                end
            end
            ST_DISCARD: begin
                // Only the newest redirect target survives; the old word is never pushed.
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_d = redirect_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (ack_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
            rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= PC_W'(RESET_PC);
            req_addr_q <= {PC_W{1'b0}};
            outst_q    <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            outst_q    <= outst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are masked by the empty flag so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            inst_mem_q[wr_ptr_q] <= imem_data;
            pcp_mem_q[wr_ptr_q]  <= pc_inc_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, drop_cnt_q;
    logic [16:0] drop_sum_s;
    logic        drop_word_s;

    assign drop_word_s    = ack_s & (redirect | (state_q == ST_DISCARD));
    assign drop_sum_s     = {1'b0, drop_cnt_q} + 17'(drop_word_s)
                          + (flush_s ? 17'(count_q) : 17'd0);
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;

    // Saturating counters of pushed words and of dropped or flushed words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 16'h0000;
            drop_cnt_q  <= 16'h0000;
        end else begin
            fetch_cnt_q <= (push_s && (fetch_cnt_q != 16'hFFFF)) ? fetch_cnt_q + 16'h0001
                                                                 : fetch_cnt_q;
            drop_cnt_q  <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end
`endif

endmodule
